// File: rtl/fft_pkg.sv
// Shared constants, write-side FSM states and the 18->16 bit saturation helper
// for the DFT/MAC output path.
package fft_pkg;

    localparam int ACC_W      = 36;
    localparam int IDX_W      = 12;
    localparam int OUT_W      = 33;
    localparam int FIFO_DEPTH = 16;
    localparam int MAX_BURST  = 16;
    localparam int BURST_W    = 5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        BURST   = 2'd2,
        DONE    = 2'd3
    } wr_state_t;

    // The value fits in 16 bits exactly when bits [17:15] are all copies of the sign.
    function automatic logic [15:0] sat18to16(input logic [17:0] v);
        if (v[17:15] == 3'b000 || v[17:15] == 3'b111) begin
            return v[15:0];
        end else if (v[17]) begin
            return 16'h8000;
        end else begin
            return 16'h7FFF;
        end
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop & ~empty;
    // A pop in the same edge frees the slot, so a full FIFO can still take a push.
    assign do_push  = push & (~full | do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/dft_result_writer.sv
// Collects finished DFT bins, saturates them to 16-bit real/imag, buffers them
// and streams the frame to the AXI write side in bursts of up to MAX_BURST beats.
module dft_result_writer
    import fft_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_start,
    input  logic [IDX_W-1:0]   i_samp_number,
    input  logic               i_bin_valid,
    input  logic [ACC_W-1:0]   i_bin_data,
    input  logic [IDX_W-1:0]   i_bin_addr,
    output logic               o_bin_ready,
    output logic [OUT_W-1:0]   o_awdata,
    output logic               o_awvalid,
    input  logic               i_awready,
    output logic [BURST_W-1:0] o_awburst,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_seq_err,
    output logic [1:0]         o_dbg_state
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    // Handshakes: a bin moves on a clock edge where i_bin_valid & o_bin_ready,
    // a beat moves where o_awvalid & i_awready; neither side may retract data
    // that has been presented until it is taken.

    wr_state_t          state, state_nxt;
    logic [IDX_W-1:0]   samp_num;
    logic [IDX_W-1:0]   exp_k;
    logic [IDX_W-1:0]   sent_cnt;
    logic [IDX_W-1:0]   remaining;
    logic [BURST_W-1:0] beat_cnt;
    logic [BURST_W-1:0] burst_reg;
    logic [BURST_W-1:0] burst_len;
    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_full;
    logic               fifo_empty;
    logic [OUT_W-1:0]   fifo_din;
    logic [OUT_W-1:0]   fifo_dout;
    logic               bin_accept;
    logic               in_frame;
    logic               store;
    logic               beat_fire;
    logic               last_beat;
    logic               start_frame;
    logic               load_burst;

    assign o_busy      = (state == COLLECT) || (state == BURST);
    assign o_bin_ready = o_busy & ~fifo_full;
    assign o_awvalid   = (state == BURST) & ~fifo_empty;
    assign o_awdata    = o_awvalid ? fifo_dout : '0;
    assign o_awburst   = (state == BURST) ? burst_reg : '0;
    assign o_dbg_state = state;

    assign bin_accept = i_bin_valid & o_bin_ready;
    // Bins beyond the frame length are consumed but never stored.
    assign in_frame   = (exp_k < samp_num);
    assign store      = bin_accept & in_frame;
    assign fifo_din   = {(exp_k == samp_num - IDX_W'(1)),
                         sat18to16(i_bin_data[35:18]),
                         sat18to16(i_bin_data[17:0])};

    assign beat_fire = o_awvalid & i_awready;
    assign last_beat = beat_fire && (beat_cnt == burst_reg);
    assign remaining = samp_num - sent_cnt;
    assign burst_len = (remaining >= IDX_W'(MAX_BURST)) ? BURST_W'(MAX_BURST)
                                                        : BURST_W'(remaining);

    sync_fifo #(
        .WIDTH (OUT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (store),
        .push_data (fifo_din),
        .pop       (beat_fire),
        .pop_data  (fifo_dout),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_nxt   = state;
        start_frame = 1'b0;
        load_burst  = 1'b0;
        case (state)
            IDLE: begin
                if (i_start) begin
                    start_frame = 1'b1;
                    state_nxt   = (i_samp_number == '0) ? DONE : COLLECT;
                end
            end
            COLLECT: begin
                if (fifo_count >= CNT_W'(burst_len)) begin
                    load_burst = 1'b1;
                    state_nxt  = BURST;
                end
            end
            BURST: begin
                if (last_beat) begin
                    state_nxt = (sent_cnt + IDX_W'(1) == samp_num) ? DONE : COLLECT;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            samp_num  <= '0;
            exp_k     <= '0;
            sent_cnt  <= '0;
            beat_cnt  <= '0;
            burst_reg <= '0;
            o_seq_err <= 1'b0;
            o_done    <= 1'b0;
        end else begin
            state  <= state_nxt;
            o_done <= (state == DONE);
            if (start_frame) begin
                samp_num  <= i_samp_number;
                exp_k     <= '0;
                sent_cnt  <= '0;
                beat_cnt  <= '0;
                o_seq_err <= 1'b0;
            end else if (bin_accept) begin
                if (!in_frame || i_bin_addr != exp_k) begin
                    o_seq_err <= 1'b1;
                end
                if (in_frame) begin
                    exp_k <= exp_k + IDX_W'(1);
                end
            end
            if (beat_fire) begin
                sent_cnt <= sent_cnt + IDX_W'(1);
                beat_cnt <= beat_cnt + BURST_W'(1);
            end
            if (load_burst) begin
                burst_reg <= burst_len - BURST_W'(1);
                beat_cnt  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_dft_result_writer.sv
// Randomised scoreboard bench for dft_result_writer: driver pushes expected beats,
// a negedge monitor pops and compares every accepted beat.
module tb_dft_result_writer;
    import fft_pkg::*;

    logic               clk;
    logic               rst;
    logic               i_start;
    logic [IDX_W-1:0]   i_samp_number;
    logic               i_bin_valid;
    logic [ACC_W-1:0]   i_bin_data;
    logic [IDX_W-1:0]   i_bin_addr;
    logic               o_bin_ready;
    logic [OUT_W-1:0]   o_awdata;
    logic               o_awvalid;
    logic               i_awready;
    logic [BURST_W-1:0] o_awburst;
    logic               o_busy;
    logic               o_done;
    logic               o_seq_err;
    logic [1:0]         o_dbg_state;

    logic [OUT_W-1:0]   exp_q[$];
    logic [BURST_W-1:0] exp_burst_q[$];

    int n_vec;
    int n_err;
    int acc_cnt;
    int frame_n;
    int beats_seen;
    int done_cnt;
    bit m_err;
    bit rdy_rand;

    dft_result_writer dut (
        .clk           (clk),
        .rst           (rst),
        .i_start       (i_start),
        .i_samp_number (i_samp_number),
        .i_bin_valid   (i_bin_valid),
        .i_bin_data    (i_bin_data),
        .i_bin_addr    (i_bin_addr),
        .o_bin_ready   (o_bin_ready),
        .o_awdata      (o_awdata),
        .o_awvalid     (o_awvalid),
        .i_awready     (i_awready),
        .o_awburst     (o_awburst),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_seq_err     (o_seq_err),
        .o_dbg_state   (o_dbg_state)
    );

    // ---------------- clock / reset / watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_rand) i_awready = 1'($urandom_range(0, 1));
        end
    end

    // ---------------- helpers and reference model
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: got timeout/unexpected event expected none", name);
    endtask

    function automatic int clamp16(input int v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic logic [OUT_W-1:0] model_beat(input logic [ACC_W-1:0] d, input bit last);
        int re;
        int im;
        logic [15:0] r16;
        logic [15:0] i16;
        re  = int'($signed(d[35:18]));
        im  = int'($signed(d[17:0]));
        r16 = 16'(clamp16(re));
        i16 = 16'(clamp16(im));
        return {last, r16, i16};
    endfunction

    function automatic logic [ACC_W-1:0] rand_data();
        return {4'($urandom), 32'($urandom)};
    endfunction

    // ---------------- driver tasks (entered at posedge + #1)
    task automatic start_frame(input int n);
        int rem;
        int b;
        i_start       = 1'b1;
        i_samp_number = IDX_W'(n);
        frame_n       = n;
        acc_cnt       = 0;
        m_err         = 1'b0;
        done_cnt      = 0;
        beats_seen    = 0;
        rem = n;
        while (rem > 0) begin
            b = (rem > MAX_BURST) ? MAX_BURST : rem;
            for (int j = 0; j < b; j++) exp_burst_q.push_back(BURST_W'(b - 1));
            rem -= b;
        end
        @(posedge clk);
        #1;
        i_start = 1'b0;
    endtask

    task automatic send_bin(input int addr, input logic [ACC_W-1:0] data);
        bit ok;
        ok          = 1'b0;
        i_bin_valid = 1'b1;
        i_bin_addr  = IDX_W'(addr);
        i_bin_data  = data;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (o_bin_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            fail_now("bin_ready_timeout");
            i_bin_valid = 1'b0;
            return;
        end
        if (addr != acc_cnt || acc_cnt >= frame_n) m_err = 1'b1;
        if (acc_cnt < frame_n) begin
            exp_q.push_back(model_beat(data, acc_cnt == frame_n - 1));
            acc_cnt++;
        end
        @(posedge clk);
        #1;
        i_bin_valid = 1'b0;
    endtask

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk);
            if (o_done) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("done_timeout");
        repeat (3) @(negedge clk);
        check("done_once", done_cnt, 1);
        check("queue_drained", exp_q.size(), 0);
        check("seq_err_end", o_seq_err, m_err);
        check("busy_after", o_busy, 0);
        @(posedge clk);
        #1;
    endtask

    // ---------------- monitor / scoreboard
    initial begin
        logic [OUT_W-1:0]   hold_data;
        logic [BURST_W-1:0] hold_burst;
        bit hold;
        hold = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold = 1'b0;
                continue;
            end
            if (hold) begin
                check("awdata_hold", o_awdata, hold_data);
                check("awburst_hold", o_awburst, hold_burst);
                check("awvalid_hold", o_awvalid, 1);
            end
            if (o_awvalid) begin
                if (i_awready) begin
                    if (exp_q.size() == 0 || exp_burst_q.size() == 0) begin
                        fail_now("unexpected_beat");
                    end else begin
                        check("awdata", o_awdata, exp_q.pop_front());
                        check("awburst", o_awburst, exp_burst_q.pop_front());
                    end
                    beats_seen++;
                    hold = 1'b0;
                end else begin
                    hold       = 1'b1;
                    hold_data  = o_awdata;
                    hold_burst = o_awburst;
                end
            end else begin
                hold = 1'b0;
            end
            if (o_done) done_cnt++;
        end
    end

    // ---------------- test sequence
    initial begin
        bit ok;
        n_vec = 0;   n_err = 0;   rdy_rand = 1'b0;
        frame_n = 0; acc_cnt = 0; beats_seen = 0; done_cnt = 0; m_err = 1'b0;
        rst = 1'b1;  i_start = 1'b0; i_samp_number = '0;
        i_bin_valid = 1'b0; i_bin_data = '0; i_bin_addr = '0; i_awready = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_awvalid", o_awvalid, 0);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_seq_err", o_seq_err, 0);
        check("rst_bin_ready", o_bin_ready, 0);
        check("rst_awburst", o_awburst, 0);
        check("rst_state", o_dbg_state, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // 20 back-to-back bins, sink always ready: bursts of 16 then 4
        i_awready = 1'b1;
        start_frame(20);
        for (int i = 0; i < 20; i++) send_bin(i, rand_data());
        wait_done();

        // saturation corners with a random sink
        rdy_rand = 1'b1;
        start_frame(5);
        send_bin(0, {18'h3FFFF, 18'h0FFFF});
        send_bin(1, {18'h20000, 18'h1FFFF});
        send_bin(2, {18'h07FFF, 18'h38000});
        send_bin(3, {18'h08000, 18'h37FFF});
        send_bin(4, {18'h00000, 18'h3FFFF});
        wait_done();

        // random frame lengths and data
        for (int f = 0; f < 4; f++) begin
            int n;
            n = $urandom_range(1, 40);
            start_frame(n);
            for (int i = 0; i < n; i++) send_bin(i, rand_data());
            wait_done();
        end

        // sink stalled: FIFO fills, bin_ready drops, recovers after first pop
        rdy_rand  = 1'b0;
        i_awready = 1'b0;
        start_frame(20);
        fork
            for (int i = 0; i < 20; i++) send_bin(i, rand_data());
        join_none
        ok = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(posedge clk);
            #2;
            if (acc_cnt >= 16) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("fill_timeout");
        @(negedge clk);
        check("full_bin_ready", o_bin_ready, 0);
        repeat (5) @(negedge clk);
        check("stall_awvalid", o_awvalid, 1);
        check("stall_awburst", o_awburst, 15);
        @(posedge clk);
        #1;
        i_awready = 1'b1;
        @(negedge clk);
        check("pre_pop_bin_ready", o_bin_ready, 0);
        @(negedge clk);
        check("post_pop_bin_ready", o_bin_ready, 1);
        wait fork;
        wait_done();

        // out-of-order index: 0,1,3
        start_frame(3);
        send_bin(0, rand_data());
        send_bin(1, rand_data());
        check("seq_err_clean", o_seq_err, 0);
        send_bin(3, rand_data());
        check("seq_err_set", o_seq_err, 1);
        wait_done();
        check("seq_err_sticky", o_seq_err, 1);
        start_frame(2);
        check("seq_err_cleared", o_seq_err, 0);
        send_bin(0, rand_data());
        send_bin(1, rand_data());
        wait_done();

        // empty frame: no beats, done two cycles after start
        start_frame(0);
        @(negedge clk);
        check("zero_done_c1", o_done, 0);
        @(negedge clk);
        check("zero_done_c2", o_done, 1);
        check("zero_busy", o_busy, 0);
        @(negedge clk);
        check("zero_done_c3", o_done, 0);
        @(posedge clk);
        #1;

        // reset during the second burst, then a clean 4-bin frame
        start_frame(20);
        fork
            for (int i = 0; i < 20; i++) send_bin(i, rand_data());
        join_none
        ok = 1'b0;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (beats_seen >= 17) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("burst2_timeout");
        check("pre_rst_awvalid", o_awvalid, 1);
        #1;
        rst = 1'b1;
        #1;
        check("rst_mid_awvalid", o_awvalid, 0);
        check("rst_mid_busy", o_busy, 0);
        wait fork;
        exp_q.delete();
        exp_burst_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("post_rst_state", o_dbg_state, 0);
        start_frame(4);
        for (int i = 0; i < 4; i++) send_bin(i, rand_data());
        wait_done();
        check("post_rst_beats", beats_seen, 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
